mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage plus MEM/WB pipeline register; consumes the EX/MEM latch outputs and produces the write-back latch outputs.
- Drives the per-core dcache request and holds it until dhit.
- Raises a stall to the hazard unit while an access is outstanding, and buffers load data if the pipeline cannot advance on the hit cycle.
- Holds the per-core LR/SC reservation, which is invalidated by coherence snoops.

Parameters:
LINK_LSB, 2, lowest address bit compared for reservation match (word granularity)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
en  in  1  pipeline advance enable from hazard unit
flush  in  1  zero the MEM/WB register
xm_dREN  in  1  load request from EX/MEM
xm_dWEN  in  1  store request from EX/MEM
xm_atomic  in  1  LR when with dREN, SC when with dWEN
xm_port_out  in  32  ALU result / data address
xm_rdat2  in  32  store data
xm_npc  in  32  next PC
xm_curr_pc  in  32  current PC
xm_zeroExt  in  32  extended immediate
xm_rd  in  5  destination register
xm_regWr  in  1  register write enable
xm_rdSel  in  3  write-back mux select
xm_halt  in  1  halt marker
dhit  in  1  dcache access complete
dmemload  in  32  dcache read data
ccinv  in  1  coherence invalidate valid
ccsnoopaddr  in  32  invalidated address
dmemREN  out  1  dcache read request
dmemWEN  out  1  dcache write request
dmemaddr  out  32  dcache address (= xm_port_out)
dmemstore  out  32  dcache store data (= xm_rdat2)
mem_stall  out  1  memory access outstanding
wb_dload  out  32  load data or SC result (1 = success, 0 = fail)
wb_port_out, wb_npc, wb_curr_pc, wb_zeroExt  out  32 each  registered copies
wb_rd  out  5  registered destination
wb_regWr  out  1  registered write enable
wb_rdSel  out  3  registered select
wb_halt  out  1  registered halt

Behaviour:
- Reset (RST high, asynchronous): all wb_* = 0, state = IDLE, link_valid = 0, link_addr = 0, load buffer = 0.
- Combinational outputs:
  - dmemREN = 0 and dmemWEN = 0 whenever RST is high.
  - mem_op = (xm_dREN | xm_dWEN) & ~xm_halt & ~sc_fail.
  - sc_fail = xm_dWEN & xm_atomic & ~(link_valid & link_addr[31:LINK_LSB] == xm_port_out[31:LINK_LSB]).
- FSM states: IDLE, WAIT, DONE.
  - IDLE, mem_op = 0: no request, mem_stall = 0.
  - IDLE, mem_op = 1: request asserted combinationally in the same cycle.
    - dhit & en: complete, stay IDLE.
    - dhit & ~en: capture dmemload into the buffer, go DONE.
    - ~dhit: go WAIT, mem_stall = 1.
  - WAIT: request held, mem_stall = ~dhit.
    - dhit & en: go IDLE.
    - dhit & ~en: capture buffer, go DONE.
  - DONE: requests deasserted, mem_stall = 0; go IDLE when en = 1. Prevents a repeated store or load while another stage stalls.
- MEM/WB register update:
  - Loads when en & ~mem_stall. wb_dload takes:
    - dmemload on a hit cycle;
    - the buffer in DONE;
    - 1/0 for SC success/fail.
  - flush has priority over en: all wb_* = 0.
  - Otherwise all wb_* hold.
- Reservation:
  - LR completion (dhit on atomic load) sets link_valid = 1 and link_addr = xm_port_out.
  - SC completion or SC fail clears link_valid.
  - A non-atomic store hit whose address matches link_addr clears link_valid.
  - ccinv with ccsnoopaddr matching link_addr clears link_valid.
  - Snoop clear wins over LR set in the same cycle.
- SC fail: no dcache request is issued; completes in zero wait cycles.
- xm_halt: no request is issued; wb_halt is registered through like any other field.
- Reset mid-WAIT: requests drop immediately and state returns to IDLE. The cache must tolerate an abandoned request.

Decomposition:
- cpu_types_pkg: word_t, the mem-stage state enum (IDLE/WAIT/DONE), and the rdSel encodings.
- Sub-module link_reg: the reservation register and its match/clear logic, plus the LINK_LSB compare.
- FSM and MEM/WB register stay in the top module.

Test Plan:
- Load to 0x100 hits after 3 cycles, en = 1 → mem_stall high for 3 cycles, dmemREN held, wb_dload = 0xDEADBEEF one cycle after dhit.
- Store hits with en = 0 for 2 cycles → one dhit, dmemWEN low during DONE, no second write, advances when en rises.
- LR 0x200, then SC 0x200 → SC write issued, wb_dload = 1, link_valid = 0 afterwards.
- LR 0x200, ccinv with ccsnoopaddr = 0x204 (LINK_LSB = 2, different word) → reservation kept. Then ccinv 0x200 → cleared; SC gives no dmemWEN, wb_dload = 0, mem_stall = 0.
- flush and en both high with a valid load → all wb_* = 0.
- RST asserted during WAIT → dmemREN = 0 asynchronously, all wb_* = 0, IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_types_pkg: shared word, mem-stage state and MEM/WB record types
// Rev 1.0
// ------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

  localparam logic [2:0] RDSEL_ALU  = 3'd0;
  localparam logic [2:0] RDSEL_LOAD = 3'd1;
  localparam logic [2:0] RDSEL_NPC  = 3'd2;
  localparam logic [2:0] RDSEL_IMM  = 3'd3;

  typedef struct packed {
    word_t       dload;
    word_t       port_out;
    word_t       npc;
    word_t       curr_pc;
    word_t       zeroExt;
    logic [4:0]  rd;
    logic        regWr;
    logic [2:0]  rdSel;
    logic        halt;
  } memwb_t;

endpackage
`default_nettype wire

// File: rtl/link_reg.sv
`default_nettype none
// ------------------------------------------------------------------
// link_reg: LR/SC reservation register with word-granular matching
// Rev 1.0
// ------------------------------------------------------------------
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int LINK_LSB = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  lr_done_i,
  input  logic  sc_clear_i,
  input  logic  st_hit_i,
  input  word_t addr_i,
  input  logic  snoop_valid_i,
  input  word_t snoop_addr_i,
  output logic  link_match_o
);

  localparam word_t TAG_MASK = ~word_t'((32'd1 << LINK_LSB) - 32'd1);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;

  function automatic logic tag_eq(input word_t a, input word_t b);
    return ((a ^ b) & TAG_MASK) == '0;
  endfunction

  assign link_match_o = valid_q && tag_eq(addr_q, addr_i);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (lr_done_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end
    if (sc_clear_i || (st_hit_i && tag_eq(addr_q, addr_i))) begin
      valid_d = 1'b0;
    end
    // Snoop is checked against the post-LR address so it wins a same-cycle set.
    if (snoop_valid_i && tag_eq(addr_d, snoop_addr_i)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_access_stage: memory stage, dcache handshake and MEM/WB register
// Rev 1.0
// ------------------------------------------------------------------
module mem_access_stage
  import cpu_types_pkg::*;
#(
  parameter int LINK_LSB = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        flush,
  input  logic        xm_dREN,
  input  logic        xm_dWEN,
  input  logic        xm_atomic,
  input  logic [31:0] xm_port_out,
  input  logic [31:0] xm_rdat2,
  input  logic [31:0] xm_npc,
  input  logic [31:0] xm_curr_pc,
  input  logic [31:0] xm_zeroExt,
  input  logic [4:0]  xm_rd,
  input  logic        xm_regWr,
  input  logic [2:0]  xm_rdSel,
  input  logic        xm_halt,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] wb_dload,
  output logic [31:0] wb_port_out,
  output logic [31:0] wb_npc,
  output logic [31:0] wb_curr_pc,
  output logic [31:0] wb_zeroExt,
  output logic [4:0]  wb_rd,
  output logic        wb_regWr,
  output logic [2:0]  wb_rdSel,
  output logic        wb_halt
);

  mem_state_e state_q, state_d;
  memwb_t     wb_q, wb_d;
  word_t      buf_q, buf_d;
  logic       req, capture, hit_done;
  logic       link_match, is_sc, sc_fail, mem_op;
  word_t      res;

  assign is_sc   = xm_dWEN & xm_atomic;
  assign sc_fail = is_sc & ~link_match;
  assign mem_op  = (xm_dREN | xm_dWEN) & ~xm_halt & ~sc_fail;
  assign res     = is_sc ? {31'b0, ~sc_fail} : dmemload;

  assign dmemREN   = req & xm_dREN & ~RST;
  assign dmemWEN   = req & xm_dWEN & ~RST;
  assign dmemaddr  = xm_port_out;
  assign dmemstore = xm_rdat2;

  link_reg #(
    .LINK_LSB (LINK_LSB)
  ) u_link (
    .clk_i         (CLK),
    .rst_i         (RST),
    .lr_done_i     (hit_done & xm_dREN & xm_atomic),
    .sc_clear_i    (is_sc & (hit_done | sc_fail)),
    .st_hit_i      (hit_done & xm_dWEN & ~xm_atomic),
    .addr_i        (xm_port_out),
    .snoop_valid_i (ccinv),
    .snoop_addr_i  (ccsnoopaddr),
    .link_match_o  (link_match)
  );

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    mem_stall = 1'b0;
    capture   = 1'b0;
    hit_done  = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (mem_op) begin
          req = 1'b1;
          if (dhit) begin
            hit_done = 1'b1;
            if (!en) begin
              capture = 1'b1;
              state_d = MS_DONE;
            end
          end else begin
            mem_stall = 1'b1;
            state_d   = MS_WAIT;
          end
        end
      end
      MS_WAIT: begin
        req       = 1'b1;
        mem_stall = ~dhit;
        if (dhit) begin
          hit_done = 1'b1;
          if (en) begin
            state_d = MS_IDLE;
          end else begin
            capture = 1'b1;
            state_d = MS_DONE;
          end
        end
      end
      // Access already performed; hold off until the pipeline moves on.
      MS_DONE: begin
        if (en) begin
          state_d = MS_IDLE;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  assign buf_d = capture ? res : buf_q;

  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = '0;
    end else if (en && !mem_stall) begin
      wb_d.dload    = (state_q == MS_DONE) ? buf_q : (hit_done ? res : '0);
      wb_d.port_out = xm_port_out;
      wb_d.npc      = xm_npc;
      wb_d.curr_pc  = xm_curr_pc;
      wb_d.zeroExt  = xm_zeroExt;
      wb_d.rd       = xm_rd;
      wb_d.regWr    = xm_regWr;
      wb_d.rdSel    = xm_rdSel;
      wb_d.halt     = xm_halt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= MS_IDLE;
      buf_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_dload    = wb_q.dload;
  assign wb_port_out = wb_q.port_out;
  assign wb_npc      = wb_q.npc;
  assign wb_curr_pc  = wb_q.curr_pc;
  assign wb_zeroExt  = wb_q.zeroExt;
  assign wb_rd       = wb_q.rd;
  assign wb_regWr    = wb_q.regWr;
  assign wb_rdSel    = wb_q.rdSel;
  assign wb_halt     = wb_q.halt;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_access_stage: vector table plus scoreboarded corner sequences
// Rev 1.0
// ------------------------------------------------------------------
module tb_mem_access_stage;
  import cpu_types_pkg::*;

  logic        CLK, RST, en, flush;
  logic        xm_dREN, xm_dWEN, xm_atomic, xm_regWr, xm_halt, dhit, ccinv;
  word_t       xm_port_out, xm_rdat2, xm_npc, xm_curr_pc, xm_zeroExt, dmemload, ccsnoopaddr;
  logic [4:0]  xm_rd;
  logic [2:0]  xm_rdSel;
  logic        dmemREN, dmemWEN, mem_stall, wb_regWr, wb_halt;
  word_t       dmemaddr, dmemstore, wb_dload, wb_port_out, wb_npc, wb_curr_pc, wb_zeroExt;
  logic [4:0]  wb_rd;
  logic [2:0]  wb_rdSel;

  mem_access_stage #(.LINK_LSB(2)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .xm_dREN(xm_dREN), .xm_dWEN(xm_dWEN), .xm_atomic(xm_atomic),
    .xm_port_out(xm_port_out), .xm_rdat2(xm_rdat2), .xm_npc(xm_npc),
    .xm_curr_pc(xm_curr_pc), .xm_zeroExt(xm_zeroExt), .xm_rd(xm_rd),
    .xm_regWr(xm_regWr), .xm_rdSel(xm_rdSel), .xm_halt(xm_halt),
    .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_dload(wb_dload), .wb_port_out(wb_port_out),
    .wb_npc(wb_npc), .wb_curr_pc(wb_curr_pc), .wb_zeroExt(wb_zeroExt),
    .wb_rd(wb_rd), .wb_regWr(wb_regWr), .wb_rdSel(wb_rdSel), .wb_halt(wb_halt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic  dren, dwen, atomic, halt, hit;
    word_t addr, wdata, load;
    logic  exp_ren, exp_wen;
    word_t exp_dload;
  } vec_t;

  typedef struct {
    word_t      dload, pc, addr;
    logic [4:0] rd;
    logic       halt;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  exp_t       sb[$];
  vec_t       vec[15];
  logic [4:0] next_rd = 5'd1;
  word_t      pc_ctr  = 32'h1000;
  word_t      last_pc = '0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble();
    xm_dREN = 0; xm_dWEN = 0; xm_atomic = 0; xm_halt = 0; xm_regWr = 0;
    dhit = 0; ccinv = 0; ccsnoopaddr = '0;
  endtask

  task automatic issue(input logic dren, input logic dwen, input logic atomic,
                       input logic halt, input word_t addr, input word_t wdata);
    xm_dREN = dren; xm_dWEN = dwen; xm_atomic = atomic; xm_halt = halt;
    xm_port_out = addr; xm_rdat2 = wdata; xm_zeroExt = addr;
    xm_curr_pc = pc_ctr; xm_npc = pc_ctr + 32'd4; xm_rd = next_rd;
    xm_regWr = 1'b1; xm_rdSel = RDSEL_LOAD;
    pc_ctr  = pc_ctr + 32'd4;
    next_rd = next_rd + 5'd1;
  endtask

  task automatic push(input word_t dload);
    exp_t e;
    e.dload = dload; e.pc = xm_curr_pc; e.addr = xm_port_out;
    e.rd = xm_rd; e.halt = xm_halt;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got empty scoreboard, expected entry", name);
    end else begin
      e = sb.pop_front();
      last_pc = e.pc;
      chk({name, " dload"}, wb_dload, e.dload);
      chk({name, " pc"}, wb_curr_pc, e.pc);
      chk({name, " npc/addr"}, wb_npc ^ wb_port_out, (e.pc + 32'd4) ^ e.addr);
      chk({name, " ctl"}, {22'b0, wb_rd, wb_regWr, wb_rdSel, wb_halt},
          {22'b0, e.rd, 1'b1, RDSEL_LOAD, e.halt});
    end
  endtask

  task automatic chk_wb_zero(input string name);
    chk({name, " wb dload"}, wb_dload, '0);
    chk({name, " wb pc"}, wb_curr_pc | wb_npc | wb_port_out | wb_zeroExt, '0);
    chk({name, " wb ctl"}, {22'b0, wb_rd, wb_regWr, wb_rdSel, wb_halt}, '0);
  endtask

  initial begin
    // dren dwen atom halt hit  addr  wdata  load  ren wen  dload
    vec[0]  = '{1, 0, 0, 0, 1, 32'h040, 32'h0,    32'h11111111, 1, 0, 32'h11111111};
    vec[1]  = '{0, 1, 0, 0, 1, 32'h044, 32'hABCD, 32'h22222222, 0, 1, 32'h22222222};
    vec[2]  = '{0, 0, 0, 0, 0, 32'h048, 32'h0,    32'h0,        0, 0, 32'h0};
    vec[3]  = '{1, 0, 0, 1, 0, 32'h04C, 32'h0,    32'h0,        0, 0, 32'h0};
    vec[4]  = '{0, 1, 1, 0, 1, 32'h200, 32'h5,    32'h33,       0, 0, 32'h0};
    vec[5]  = '{1, 0, 1, 0, 1, 32'h200, 32'h0,    32'hCAFE0001, 1, 0, 32'hCAFE0001};
    vec[6]  = '{0, 1, 1, 0, 1, 32'h200, 32'h7,    32'h44,       0, 1, 32'h1};
    vec[7]  = '{0, 1, 1, 0, 1, 32'h200, 32'h7,    32'h44,       0, 0, 32'h0};
    vec[8]  = '{1, 0, 1, 0, 1, 32'h300, 32'h0,    32'h55,       1, 0, 32'h55};
    vec[9]  = '{0, 1, 0, 0, 1, 32'h300, 32'h9,    32'h66,       0, 1, 32'h66};
    vec[10] = '{0, 1, 1, 0, 1, 32'h300, 32'h9,    32'h77,       0, 0, 32'h0};
    vec[11] = '{1, 0, 1, 0, 1, 32'h400, 32'h0,    32'h88,       1, 0, 32'h88};
    vec[12] = '{0, 1, 1, 0, 1, 32'h403, 32'h1,    32'h99,       0, 1, 32'h1};
    vec[13] = '{1, 0, 1, 0, 1, 32'h400, 32'h0,    32'hAA,       1, 0, 32'hAA};
    vec[14] = '{0, 1, 1, 0, 1, 32'h404, 32'h1,    32'hBB,       0, 0, 32'h0};

    RST = 1; en = 1; flush = 0; dmemload = '0;
    xm_port_out = '0; xm_rdat2 = '0; xm_npc = '0; xm_curr_pc = '0; xm_zeroExt = '0;
    xm_rd = '0; xm_rdSel = '0;
    bubble();
    repeat (2) @(posedge CLK);
    #1;
    chk_wb_zero("reset");
    xm_dREN = 1; dhit = 0;
    #1;
    chk("reset dmemREN", {31'b0, dmemREN}, 32'd0);
    xm_dREN = 0;
    RST = 0;
    tick();

    foreach (vec[i]) begin
      issue(vec[i].dren, vec[i].dwen, vec[i].atomic, vec[i].halt, vec[i].addr, vec[i].wdata);
      dhit = vec[i].hit; dmemload = vec[i].load;
      push(vec[i].exp_dload);
      #1;
      chk($sformatf("row%0d req", i), {30'b0, dmemREN, dmemWEN}, {30'b0, vec[i].exp_ren, vec[i].exp_wen});
      chk($sformatf("row%0d stall", i), {31'b0, mem_stall}, 32'd0);
      chk($sformatf("row%0d addr", i), dmemaddr ^ dmemstore, vec[i].addr ^ vec[i].wdata);
      tick();
      pop_chk($sformatf("row%0d", i));
    end

    // Load with three miss cycles before the hit.
    issue(1, 0, 0, 0, 32'h100, 32'h0);
    dhit = 0; dmemload = 32'h0;
    push(32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("waitld stall%0d", k), {30'b0, mem_stall, dmemREN}, 32'd3);
      tick();
    end
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    chk("waitld hit", {30'b0, mem_stall, dmemREN}, 32'd1);
    tick();
    pop_chk("waitld");
    bubble();
    #1;
    chk("waitld release", {31'b0, dmemREN}, 32'd0);
    tick();

    // Store hits while the pipeline is frozen for two cycles.
    issue(0, 1, 0, 0, 32'h104, 32'h77);
    dhit = 1; dmemload = 32'h5A5A5A5A; en = 0;
    push(32'h5A5A5A5A);
    #1;
    chk("frz hit wen", {31'b0, dmemWEN}, 32'd1);
    tick();
    dhit = 0; dmemload = 32'h0BADF00D;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("frz done%0d", k), {29'b0, dmemWEN, dmemREN, mem_stall}, 32'd0);
      chk($sformatf("frz hold%0d", k), wb_curr_pc, last_pc);
      tick();
    end
    en = 1;
    #1;
    chk("frz adv wen", {31'b0, dmemWEN}, 32'd0);
    tick();
    pop_chk("frz");
    bubble();
    tick();

    // Reservation survives a snoop to the neighbouring word.
    issue(1, 0, 1, 0, 32'h200, 32'h0);
    dhit = 1; dmemload = 32'h12345678;
    push(32'h12345678);
    tick();
    pop_chk("lr1");
    bubble(); ccinv = 1; ccsnoopaddr = 32'h204;
    tick();
    ccinv = 0;
    issue(0, 1, 1, 0, 32'h200, 32'h3);
    dhit = 1;
    push(32'd1);
    #1;
    chk("sc1 wen", {31'b0, dmemWEN}, 32'd1);
    tick();
    pop_chk("sc1");

    // Matching snoop kills the reservation.
    issue(1, 0, 1, 0, 32'h200, 32'h0);
    dhit = 1; dmemload = 32'h0000ABCD;
    push(32'h0000ABCD);
    tick();
    pop_chk("lr2");
    bubble(); ccinv = 1; ccsnoopaddr = 32'h200;
    tick();
    ccinv = 0;
    issue(0, 1, 1, 0, 32'h200, 32'h3);
    dhit = 1;
    push(32'd0);
    #1;
    chk("sc2 nowrite", {30'b0, dmemWEN, mem_stall}, 32'd0);
    tick();
    pop_chk("sc2");

    // Snoop in the same cycle as the LR completion wins.
    issue(1, 0, 1, 0, 32'h500, 32'h0);
    dhit = 1; dmemload = 32'h00C0FFEE; ccinv = 1; ccsnoopaddr = 32'h500;
    push(32'h00C0FFEE);
    tick();
    pop_chk("lr3");
    ccinv = 0;
    issue(0, 1, 1, 0, 32'h500, 32'h3);
    dhit = 1;
    push(32'd0);
    #1;
    chk("sc3 nowrite", {31'b0, dmemWEN}, 32'd0);
    tick();
    pop_chk("sc3");

    // Flush beats enable.
    issue(1, 0, 0, 0, 32'h600, 32'h0);
    dhit = 1; dmemload = 32'h66666666; flush = 1;
    tick();
    flush = 0;
    chk_wb_zero("flush");

    // Reset while waiting on the cache.
    issue(1, 0, 0, 0, 32'h700, 32'h0);
    dhit = 1; dmemload = 32'h70707070;
    push(32'h70707070);
    tick();
    pop_chk("prerst");
    issue(1, 0, 0, 0, 32'h704, 32'h0);
    dhit = 0;
    tick();
    chk("rst wait ren", {30'b0, dmemREN, mem_stall}, 32'd3);
    RST = 1;
    #1;
    chk("rst async ren", {31'b0, dmemREN}, 32'd0);
    chk_wb_zero("rst async");
    bubble();
    tick();
    RST = 0;
    #1;
    chk("rst idle", {30'b0, dmemREN, mem_stall}, 32'd0);
    tick();

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard drain: got %0d left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
